regfile_wb_ctrl: RTL and testbench

- Write-port controller for the 32x32 register file.
- After reset it sweeps zeros into all 32 registers.
- It then arbitrates the single write port round-robin between two writeback requesters (0 = ALU, 1 = load unit).
- It keeps a 32-bit busy scoreboard used by the issue stage for RAW stall detection.
- It drives the register file's write data, write address and write enable directly from registered outputs.

---
 rtl/regfile_wb_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-port controller for the 32x32 register file.
// After reset it optionally sweeps zeros into all 32 registers. It then
// arbitrates the single write port round-robin between two writeback
// requesters (0 = ALU, 1 = load unit). It also keeps the busy scoreboard
// that the issue stage uses for RAW stall detection.
//
// Ports:
//   clk, clr                  clock (rising edge), async active-low reset
//   reqN_valid/addr/data      writeback request from requester N
//   reqN_ready                requester N accepted this cycle (combinational)
//   issue_valid, issue_rd     instruction issued with destination issue_rd
//   busy                      scoreboard, bit i = write to xi pending
//   rf_we, rf_addr, rf_d      registered register-file write port
//   init_done                 high once in RUN
module regfile_wb_ctrl #(
  parameter bit INIT_SWEEP = 1'b1,
  parameter bit RST_PRIO   = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_d,
  output logic        init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        ptr;
  logic        run;
  logic        grant0;
  logic        grant1;
  logic        acc;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] busy_next;

  assign run = (state == ST_RUN);

  // ptr selects the winner only when both requesters are valid.
  always_comb begin
    grant0  = run & req0_valid & (~req1_valid | ~ptr);
    grant1  = run & req1_valid & (~req0_valid | ptr);
    acc     = grant0 | grant1;
    wr_addr = grant1 ? req1_addr : req0_addr;
    wr_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Set is applied after clear so a new producer issued in the same cycle
  // as the old one's writeback keeps the register marked busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid) set_mask[issue_rd] = 1'b1;
    if (acc)         clr_mask[wr_addr]  = 1'b1;
    set_mask[0] = 1'b0;
    clr_mask[0] = 1'b0;
    busy_next = (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= INIT_SWEEP ? ST_INIT : ST_RUN;
      cnt       <= '0;
      ptr       <= RST_PRIO;
      busy      <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_d      <= '0;
      init_done <= ~INIT_SWEEP;
    end else if (state == ST_INIT) begin
      rf_we   <= 1'b1;
      rf_addr <= cnt;
      rf_d    <= '0;
      cnt     <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end else begin
      // Writes to x0 are acknowledged but never reach the register file.
      rf_we <= acc & (wr_addr != 5'd0);
      if (acc && (wr_addr != 5'd0)) begin
        rf_addr <= wr_addr;
        rf_d    <= wr_data;
      end
      if (req0_valid && req1_valid) ptr <= ~ptr;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed sweep/contention/
// scoreboard/x0/reset cases plus randomized traffic against a rule-level model.
module tb_regfile_wb_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        r0v, r1v, r0r, r1r, iv;
  logic [4:0]  r0a, r1a, ird;
  logic [31:0] r0d, r1d;
  logic [31:0] busy;
  logic        rf_we, init_done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_d;

  logic        n_clr;
  logic        n_r0v, n_r1v, n_r0r, n_r1r;
  logic [4:0]  n_r0a, n_r1a;
  logic [31:0] n_r0d, n_r1d;
  logic [31:0] n_busy;
  logic        n_rf_we, n_init_done;
  logic [4:0]  n_rf_addr;
  logic [31:0] n_rf_d;

  regfile_wb_ctrl #(.INIT_SWEEP(1'b1), .RST_PRIO(1'b0)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1r),
    .issue_valid(iv), .issue_rd(ird), .busy(busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_d(rf_d), .init_done(init_done)
  );

  regfile_wb_ctrl #(.INIT_SWEEP(1'b0), .RST_PRIO(1'b1)) dut_ns (
    .clk(clk), .clr(n_clr),
    .req0_valid(n_r0v), .req0_addr(n_r0a), .req0_data(n_r0d), .req0_ready(n_r0r),
    .req1_valid(n_r1v), .req1_addr(n_r1a), .req1_data(n_r1d), .req1_ready(n_r1r),
    .issue_valid(1'b0), .issue_rd(5'd0), .busy(n_busy),
    .rf_we(n_rf_we), .rf_addr(n_rf_addr), .rf_d(n_rf_d), .init_done(n_init_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds priority, which registers are pending,
  // and what the write port last carried.
  int          m_ptr;
  bit          m_busy [32];
  logic [4:0]  m_addr;
  logic [31:0] m_d;
  bit          g0, g1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Called just after a falling edge with inputs stable; returns at the next
  // falling edge. g0/g1 hold the model's grant for the cycle.
  task automatic run_cycle();
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    bit          any;
    #1;
    g0 = r0v && (!r1v || m_ptr == 0);
    g1 = r1v && (!r0v || m_ptr == 1);
    check("ready0", {31'd0, r0r}, {31'd0, g0});
    check("ready1", {31'd0, r1r}, {31'd0, g1});
    any = g0 || g1;
    a   = g1 ? r1a : r0a;
    d   = g1 ? r1d : r0d;
    we  = any && (a != 5'd0);
    if (r0v && r1v) m_ptr = 1 - m_ptr;
    for (int i = 1; i < 32; i++) begin
      if (iv && ird == 5'(i))      m_busy[i] = 1'b1;
      else if (any && a == 5'(i))  m_busy[i] = 1'b0;
    end
    if (we) begin
      m_addr = a;
      m_d    = d;
    end
    @(posedge clk);
    #1;
    check("rf_we",     {31'd0, rf_we}, {31'd0, we});
    check("rf_addr",   {27'd0, rf_addr}, {27'd0, m_addr});
    check("rf_d",      rf_d, m_d);
    check("busy",      busy, m_busy_vec());
    check("init_done", {31'd0, init_done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic drop_granted();
    if (g0) r0v = 1'b0;
    if (g1) r1v = 1'b0;
  endtask

  logic [31:0] busy_before;

  initial begin
    clr = 1'b0; n_clr = 1'b0;
    r0v = 1'b1; r0a = 5'd3; r0d = 32'h1111_2222;
    r1v = 1'b1; r1a = 5'd4; r1d = 32'h3333_4444;
    iv = 1'b1; ird = 5'd8;
    n_r0v = 1'b0; n_r0a = '0; n_r0d = '0;
    n_r1v = 1'b0; n_r1a = '0; n_r1d = '0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_rf_we",     {31'd0, rf_we}, 32'd0);
    check("rst_rf_addr",   {27'd0, rf_addr}, 32'd0);
    check("rst_rf_d",      rf_d, 32'd0);
    check("rst_busy",      busy, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_ready0",    {31'd0, r0r}, 32'd0);
    check("rst_ready1",    {31'd0, r1r}, 32'd0);

    // Zero sweep with both requesters valid and an issue pending
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      check("sweep_ready0", {31'd0, r0r}, 32'd0);
      check("sweep_ready1", {31'd0, r1r}, 32'd0);
      @(posedge clk);
      #1;
      check("sweep_we",   {31'd0, rf_we}, 32'd1);
      check("sweep_addr", {27'd0, rf_addr}, 32'(k));
      check("sweep_d",    rf_d, 32'd0);
      check("sweep_busy", busy, 32'd0);
      check("sweep_init_done", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    iv = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_addr = 5'd31;
    m_d    = 32'd0;

    // Contention: req0 first, then after pointer flip req1 first
    r0a = 5'd5; r0d = 32'hAAAA_0005;
    r1a = 5'd6; r1d = 32'hBBBB_0006;
    run_cycle();
    check("cont1_first_x5", {27'd0, rf_addr}, 32'd5);
    drop_granted();
    run_cycle();
    check("cont1_second_x6", {27'd0, rf_addr}, 32'd6);
    drop_granted();
    r0v = 1'b1; r0a = 5'd10; r0d = 32'hCCCC_000A;
    r1v = 1'b1; r1a = 5'd11; r1d = 32'hDDDD_000B;
    run_cycle();
    check("cont2_first_x11", {27'd0, rf_addr}, 32'd11);
    drop_granted();
    run_cycle();
    check("cont2_second_x10", {27'd0, rf_addr}, 32'd10);
    drop_granted();

    // Scoreboard: issue x7, written back three cycles later
    iv = 1'b1; ird = 5'd7;
    run_cycle();
    iv = 1'b0;
    check("sb_x7_set", {31'd0, busy[7]}, 32'd1);
    run_cycle();
    run_cycle();
    r1v = 1'b1; r1a = 5'd7; r1d = 32'h0000_0077;
    run_cycle();
    check("sb_x7_clear", {31'd0, busy[7]}, 32'd0);
    drop_granted();

    // Scoreboard: re-issue of x9 in the same cycle as its writeback
    iv = 1'b1; ird = 5'd9;
    run_cycle();
    r0v = 1'b1; r0a = 5'd9; r0d = 32'h0000_0099;
    run_cycle();
    check("sb_x9_newer_wins", {31'd0, busy[9]}, 32'd1);
    drop_granted();
    iv = 1'b0;

    // x0 write is acknowledged but suppressed
    r0v = 1'b1; r0a = 5'd0; r0d = 32'hDEAD_BEEF;
    run_cycle();
    check("x0_we",      {31'd0, rf_we}, 32'd0);
    check("x0_busy0",   {31'd0, busy[0]}, 32'd0);
    drop_granted();
    busy_before = busy;
    iv = 1'b1; ird = 5'd0;
    run_cycle();
    check("x0_issue_busy", busy, busy_before);
    iv = 1'b0;

    // Randomized traffic
    repeat (400) begin
      if (!r0v && ($urandom_range(0, 1) == 1)) begin
        r0v = 1'b1; r0a = 5'($urandom_range(0, 15)); r0d = $urandom;
      end
      if (!r1v && ($urandom_range(0, 1) == 1)) begin
        r1v = 1'b1; r1a = 5'($urandom_range(0, 15)); r1d = $urandom;
      end
      iv  = ($urandom_range(0, 2) == 0);
      ird = 5'($urandom_range(0, 15));
      run_cycle();
      drop_granted();
    end
    iv = 1'b1; ird = 5'd13;
    run_cycle();
    iv = 1'b0;

    // Reset while in RUN with a pending scoreboard bit
    r0v = 1'b1; r0a = 5'd2; r0d = 32'h0202_0202;
    clr = 1'b0;
    #1;
    check("run_rst_we",   {31'd0, rf_we}, 32'd0);
    check("run_rst_busy", busy, 32'd0);
    check("run_rst_init_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      #1;
      check("resweep_ready0", {31'd0, r0r}, 32'd0);
      @(posedge clk);
      #1;
      check("resweep_addr", {27'd0, rf_addr}, 32'(k));
      if (k != 12) @(negedge clk);
    end

    // Reset mid-sweep at address 12
    clr = 1'b0;
    #1;
    check("mid_rst_we",   {31'd0, rf_we}, 32'd0);
    check("mid_rst_addr", {27'd0, rf_addr}, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("restart_we",   {31'd0, rf_we}, 32'd1);
      check("restart_addr", {27'd0, rf_addr}, 32'(k));
      check("restart_busy", busy, 32'd0);
    end
    r0v = 1'b0;

    // No-sweep instance with RST_PRIO = 1
    @(negedge clk);
    n_r0v = 1'b1; n_r0a = 5'd3; n_r0d = 32'h1234_5678;
    #1;
    check("ns_rst_init_done", {31'd0, n_init_done}, 32'd1);
    check("ns_rst_we", {31'd0, n_rf_we}, 32'd0);
    @(negedge clk);
    n_clr = 1'b1;
    #1;
    check("ns_first_ready0", {31'd0, n_r0r}, 32'd1);
    check("ns_first_ready1", {31'd0, n_r1r}, 32'd0);
    @(posedge clk);
    #1;
    check("ns_first_we",   {31'd0, n_rf_we}, 32'd1);
    check("ns_first_addr", {27'd0, n_rf_addr}, 32'd3);
    check("ns_first_d",    n_rf_d, 32'h1234_5678);
    @(negedge clk);
    n_r0a = 5'd4; n_r0d = 32'h4444_4444;
    n_r1v = 1'b1; n_r1a = 5'd8; n_r1d = 32'h8888_8888;
    #1;
    check("ns_prio_ready1", {31'd0, n_r1r}, 32'd1);
    check("ns_prio_ready0", {31'd0, n_r0r}, 32'd0);
    @(posedge clk);
    #1;
    check("ns_prio_addr", {27'd0, n_rf_addr}, 32'd8);
    check("ns_prio_d",    n_rf_d, 32'h8888_8888);
    @(negedge clk);
    n_r0v = 1'b0; n_r1v = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
